rx_frame_ctrl: RTL and testbench

Receive-side frame controller for the GMII RX path. It sits between the PHY receive interface and the downstream byte consumer, and runs on `rx_clk`. It tracks the preamble and SFD, strips them, and presents payload bytes (destination MAC through FCS) with start/end markers. At end of frame it issues a good/bad verdict based on length and error checks, and it keeps saturating frame statistics.

---
 rtl/rx_frame_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: GMII receive-side frame controller.
// Strips preamble/SFD, forwards payload bytes (DA through FCS) with
// start/end markers, gives a good/bad verdict at end of frame and keeps
// saturating good/bad/drop statistics.
// Optional feature: define RX_MAC_FILTER_EN to add the my_mac port and a
// destination address check (station address or broadcast) to the verdict.
module rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MAX = 15
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    input  logic        rx_error,
`ifdef RX_MAC_FILTER_EN
    input  logic [47:0] my_mac,
`endif
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_good,
    output logic        out_bad,
    output logic [10:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [10:0] L_MIN     = 11'(MIN_LEN);
    localparam logic [10:0] L_MAX     = 11'(MAX_LEN);
    localparam logic [4:0]  L_PRE_MAX = 5'(PRE_MAX);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DROP
    } state_t;

    state_t      r_state;
    logic [4:0]  r_pre_cnt;
    logic [7:0]  r_hold;
    logic        r_have;
    logic        r_first;
    logic [10:0] r_len;
    logic        r_err;
    logic [10:0] w_len_nxt;
    logic        w_addr_ok;
    logic        w_good;

`ifdef RX_MAC_FILTER_EN
    logic        r_da_mine;
    logic        r_da_bcast;
    logic [7:0]  w_mac_byte;

    // Station address byte expected at the current DA byte position
    always_comb begin
        w_mac_byte = 8'h00;
        case (r_len[2:0])
            3'd0:    w_mac_byte = my_mac[47:40];
            3'd1:    w_mac_byte = my_mac[39:32];
            3'd2:    w_mac_byte = my_mac[31:24];
            3'd3:    w_mac_byte = my_mac[23:16];
            3'd4:    w_mac_byte = my_mac[15:8];
            3'd5:    w_mac_byte = my_mac[7:0];
            default: w_mac_byte = 8'h00;
        endcase
    end

    // A frame too short to carry a full DA never matches
    assign w_addr_ok = (r_len >= 11'd6) && (r_da_mine || r_da_bcast);
`else
    assign w_addr_ok = 1'b1;
`endif

    // Length counter saturates at 2047 so oversize frames stay flagged bad
    assign w_len_nxt = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
    assign w_good    = !r_err && (r_len >= L_MIN) && (r_len <= L_MAX) && w_addr_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Frame FSM with registered payload outputs and statistics
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            r_state    <= S_ARM;
            r_pre_cnt  <= 5'd0;
            r_hold     <= 8'h00;
            r_have     <= 1'b0;
            r_first    <= 1'b0;
            r_len      <= 11'd0;
            r_err      <= 1'b0;
`ifdef RX_MAC_FILTER_EN
            r_da_mine  <= 1'b0;
            r_da_bcast <= 1'b0;
`endif
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_good   <= 1'b0;
            out_bad    <= 1'b0;
            frame_len  <= 11'd0;
            good_cnt   <= 16'd0;
            bad_cnt    <= 16'd0;
            drop_cnt   <= 16'd0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_good  <= 1'b0;
            out_bad   <= 1'b0;
            case (r_state)
                S_ARM: begin
                    // Never lock onto a frame already in flight after reset
                    if (!rx_enable) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (rx_enable) begin
                        if (rx_data == 8'h55) begin
                            r_state   <= S_PRE;
                            r_pre_cnt <= 5'd1;
                        end else begin
                            r_state  <= S_DROP;
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end
                S_PRE: begin
                    if (!rx_enable) begin
                        r_state  <= S_IDLE;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (rx_error) begin
                        r_state  <= S_DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (rx_data == 8'h55) begin
                        if (r_pre_cnt >= L_PRE_MAX) begin
                            r_state  <= S_DROP;
                            drop_cnt <= sat_inc(drop_cnt);
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 5'd1;
                        end
                    end else if (rx_data == 8'hD5) begin
                        r_state    <= S_DATA;
                        r_have     <= 1'b0;
                        r_first    <= 1'b1;
                        r_len      <= 11'd0;
                        r_err      <= 1'b0;
`ifdef RX_MAC_FILTER_EN
                        r_da_mine  <= 1'b1;
                        r_da_bcast <= 1'b1;
`endif
                    end else begin
                        r_state  <= S_DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                end
                S_DATA: begin
                    if (rx_enable) begin
                        // Emit the previous byte; the new one waits in the hold register
                        if (r_have) begin
                            out_valid <= 1'b1;
                            out_data  <= r_hold;
                            out_sof   <= r_first;
                            r_first   <= 1'b0;
                        end
                        r_hold <= rx_data;
                        r_have <= 1'b1;
                        r_len  <= w_len_nxt;
                        if (rx_error) r_err <= 1'b1;
`ifdef RX_MAC_FILTER_EN
                        if (r_len < 11'd6) begin
                            if (rx_data != w_mac_byte) r_da_mine  <= 1'b0;
                            if (rx_data != 8'hFF)      r_da_bcast <= 1'b0;
                        end
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_have  <= 1'b0;
                        if (r_have) begin
                            out_valid <= 1'b1;
                            out_data  <= r_hold;
                            out_sof   <= r_first;
                            out_eof   <= 1'b1;
                            out_good  <= w_good;
                            out_bad   <= !w_good;
                            frame_len <= r_len;
                            r_first   <= 1'b0;
                            if (w_good) good_cnt <= sat_inc(good_cnt);
                            else        bad_cnt  <= sat_inc(bad_cnt);
                        end else begin
                            // SFD followed directly by end of carrier
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end
                S_DROP: begin
                    if (!rx_enable) r_state <= S_IDLE;
                end
                default: r_state <= S_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Testbench for rx_frame_ctrl: directed frames with a scoreboard of
// expected output bytes, checked at the falling clock edge.
module tb_rx_frame_ctrl;

    logic        rx_clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_enable;
    logic        rx_error;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_eof, out_good, out_bad;
    logic [10:0] frame_len;
    logic [15:0] good_cnt, bad_cnt, drop_cnt;

    localparam logic [47:0] MY_MAC = 48'h020000000001;

    rx_frame_ctrl dut (
        .rx_clk    (rx_clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_enable (rx_enable),
        .rx_error  (rx_error),
`ifdef RX_MAC_FILTER_EN
        .my_mac    (MY_MAC),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_good  (out_good),
        .out_bad   (out_bad),
        .frame_len (frame_len),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        good;
        logic [10:0] len;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          exp_good = 0;
    int          exp_bad  = 0;
    int          exp_drop = 0;
    logic [47:0] dest     = 48'h000102030405;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge rx_clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data", {24'd0, out_data}, {24'd0, e.d});
                chk("sof", {31'd0, out_sof}, {31'd0, e.sof});
                chk("eof", {31'd0, out_eof}, {31'd0, e.eof});
                if (e.eof) begin
                    chk("good", {31'd0, out_good}, {31'd0, e.good});
                    chk("bad", {31'd0, out_bad}, {31'd0, !e.good});
                    chk("frame_len", {21'd0, frame_len}, {21'd0, e.len});
                end
            end
        end else begin
            chk("idle_flags", {28'd0, out_sof, out_eof, out_good, out_bad}, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pay(input int i);
        logic [47:0] t;
        if (i < 6) begin
            t = dest >> (8 * (5 - i));
            return t[7:0];
        end
        return i[7:0];
    endfunction

    task automatic drive(input logic en, input logic [7:0] d, input logic er);
        @(posedge rx_clk);
        #1;
        rx_enable = en;
        rx_data   = d;
        rx_error  = er;
    endtask

    // Push expected outputs, then drive 7x0x55, SFD, n payload bytes and one idle cycle
    task automatic send_frame(input int n, input int err_idx);
        logic ok;
        exp_t e;
        ok = (err_idx < 0) && (n >= 64) && (n <= 1518);
`ifdef RX_MAC_FILTER_EN
        ok = ok && (n >= 6) && ((dest == MY_MAC) || (dest == 48'hFFFFFFFFFFFF));
`endif
        for (int i = 0; i < n; i++) begin
            e.d    = pay(i);
            e.sof  = (i == 0);
            e.eof  = (i == n - 1);
            e.good = ok;
            e.len  = (n > 2047) ? 11'h7FF : 11'(n);
            q.push_back(e);
        end
        if (n == 0)  exp_drop++;
        else if (ok) exp_good++;
        else         exp_bad++;
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < n; i++) drive(1'b1, pay(i), (i == err_idx));
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        @(negedge rx_clk);
        while (q.size() != 0 && k < 50) begin
            @(negedge rx_clk);
            k++;
        end
        repeat (2) @(negedge rx_clk);
        chk(tag, q.size(), 32'd0);
    endtask

    task automatic check_cnts(input string tag);
        chk({tag, "_good_cnt"}, {16'd0, good_cnt}, exp_good);
        chk({tag, "_bad_cnt"}, {16'd0, bad_cnt}, exp_bad);
        chk({tag, "_drop_cnt"}, {16'd0, drop_cnt}, exp_drop);
    endtask

    initial begin
        reset = 1'b1; rx_enable = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_flags", {27'd0, out_valid, out_sof, out_eof, out_good, out_bad}, 32'd0);
        chk("rst_frame_len", {21'd0, frame_len}, 32'd0);
        check_cnts("rst");
        @(posedge rx_clk); #1; reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        // Nominal 64-byte frame
        send_frame(64, -1);
        wait_drain("nominal_drain");
        check_cnts("nominal");

        // Runt then back-to-back good frame after a single idle cycle
        send_frame(60, -1);
        send_frame(64, -1);
        wait_drain("b2b_drain");
        check_cnts("b2b");

        // Preamble 55 55 5D
        drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h5D, 1'b0);
        drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h11, 1'b0); drive(1'b0, 8'h00, 1'b0);
        exp_drop++;
        wait_drain("pre_bad_drain");
        check_cnts("pre_bad");

        // 16 preamble bytes exceed the limit
        for (int i = 0; i < 16; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h22, 1'b0); drive(1'b0, 8'h00, 1'b0);
        exp_drop++;
        wait_drain("pre_long_drain");
        check_cnts("pre_long");

        // Zero-length frame and 1-byte frame
        send_frame(0, -1);
        send_frame(1, -1);
        wait_drain("short_drain");
        check_cnts("short");

        // rx_error mid-frame, length boundaries, oversize
        send_frame(100, 10);
        send_frame(1518, -1);
        send_frame(1519, -1);
        wait_drain("long_drain");
        check_cnts("long");

`ifdef RX_MAC_FILTER_EN
        dest = MY_MAC;             send_frame(64, -1);
        dest = 48'hFFFFFFFFFFFF;   send_frame(64, -1);
        dest = 48'h020000000002;   send_frame(64, -1);
        dest = 48'h000102030405;
        wait_drain("mac_drain");
        check_cnts("mac");
`endif

        // Reset mid-frame at payload byte 20, released while rx_enable is high
        for (int i = 0; i < 19; i++) begin
            exp_t e;
            e.d = pay(i); e.sof = (i == 0); e.eof = 1'b0; e.good = 1'b0; e.len = 11'd0;
            q.push_back(e);
        end
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, pay(i), 1'b0);
        drive(1'b1, 8'd20, 1'b0); reset = 1'b1;
        drive(1'b1, 8'd21, 1'b0);
        exp_good = 0; exp_bad = 0; exp_drop = 0;
        @(negedge rx_clk);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        check_cnts("midrst");
        drive(1'b1, 8'd22, 1'b0); reset = 1'b0;
        for (int i = 23; i < 40; i++) drive(1'b1, i[7:0], 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        wait_drain("midrst_drain");
        check_cnts("midrst_tail");
        send_frame(64, -1);
        wait_drain("after_rst_drain");
        check_cnts("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
